// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_queue
// Brief    : ROM instruction prefetcher with a PC-tagged FIFO, valid/ready
//            output and redirect flush. Optional macro PREFETCH_PERF_EN adds
//            a saturating count of words discarded by redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_to_rom,
    output logic              enable_to_rom,
    input  logic [DATA_W-1:0] data_from_rom,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
`ifdef PREFETCH_PERF_EN
    ,
    output logic [7:0]        perf_flush_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_tag_pc;

    logic [CNT_W-1:0]  w_occ;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;

    // Occupancy counts the in-flight read so the FIFO can never overflow.
    assign w_occ   = r_count + {{(CNT_W-1){1'b0}}, r_inflight};
    assign w_issue = !reset && !redirect && (w_occ < CNT_W'(DEPTH));
    assign w_push  = r_inflight;
    assign w_pop   = instr_valid && instr_ready;

    assign enable_to_rom  = w_issue;
    assign address_to_rom = r_fetch_pc;
    assign instr_valid    = (r_count != '0);
    assign instr_out      = r_mem_data[r_rd_ptr];
    assign instr_pc       = r_mem_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_tag_pc   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (redirect) begin
            // Dropping inflight discards the response that lands next cycle.
            r_fetch_pc <= redirect_addr;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
                r_tag_pc   <= r_fetch_pc;
            end
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= data_from_rom;
                r_mem_pc[r_wr_ptr]   <= r_tag_pc;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PREFETCH_PERF_EN
    localparam int SUM_W = (CNT_W > 8) ? CNT_W + 1 : 9;

    logic [7:0]       r_perf;
    logic [SUM_W-1:0] w_perf_sum;

    assign w_perf_sum       = SUM_W'(r_perf) + SUM_W'(w_occ);
    assign perf_flush_count = r_perf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf <= 8'h00;
        end else if (redirect) begin
            r_perf <= (w_perf_sum > SUM_W'(255)) ? 8'hFF : w_perf_sum[7:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_queue
// Brief    : Directed self-checking bench for instr_prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  address_to_rom;
    logic        enable_to_rom;
    logic [15:0] data_from_rom;
    logic [15:0] instr_out;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [5:0]  redirect_addr;
`ifdef PREFETCH_PERF_EN
    logic [7:0]  perf_flush_count;
`endif

    int total = 0;
    int bad   = 0;

    instr_prefetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (6),
        .DATA_W   (16),
        .RESET_PC (6'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address_to_rom (address_to_rom),
        .enable_to_rom  (enable_to_rom),
        .data_from_rom  (data_from_rom),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_flush_count (perf_flush_count)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: one-cycle read latency, word = {10'h0, addr}
    initial data_from_rom = 16'h0;
    always @(posedge clk) begin
        if (enable_to_rom) data_from_rom <= {10'h0, address_to_rom};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_perf(input string tag, input logic [7:0] exp_v);
`ifdef PREFETCH_PERF_EN
        chk(tag, 32'(perf_flush_count), 32'(exp_v));
`endif
    endtask

    initial begin
        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 6'd0;
        repeat (2) @(negedge clk);
        chk("rst_en",    32'(enable_to_rom), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_addr",  32'(address_to_rom), 0);
        chk("rst_out",   32'(instr_out), 0);
        chk("rst_pc",    32'(instr_pc), 0);
        chk_perf("rst_perf", 8'd0);

        // Streaming with ready=1: valid two cycles after first issue
        reset = 1'b0; instr_ready = 1'b1; #1;
        chk("t1_en0",    32'(enable_to_rom), 1);
        chk("t1_addr0",  32'(address_to_rom), 0);
        chk("t1_valid0", 32'(instr_valid), 0);
        @(negedge clk);
        chk("t1_valid1", 32'(instr_valid), 0);
        chk("t1_addr1",  32'(address_to_rom), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_valid", 32'(instr_valid), 1);
            chk("t1_pc",    32'(instr_pc), 32'(i));
            chk("t1_out",   32'(instr_out), 32'(i));
        end

        // Fill with ready=0, then drain in order
        reset = 1'b1; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; #1;
        chk("t2_en0", 32'(enable_to_rom), 1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("t2_en",   32'(enable_to_rom), 1);
            chk("t2_addr", 32'(address_to_rom), 32'(k));
        end
        @(negedge clk);
        chk("t2_full_en", 32'(enable_to_rom), 0);
        repeat (5) @(negedge clk);
        chk("t2_hold_en",    32'(enable_to_rom), 0);
        chk("t2_hold_valid", 32'(instr_valid), 1);
        chk("t2_hold_pc",    32'(instr_pc), 0);
        @(negedge clk);
        chk("t2_head_pc", 32'(instr_pc), 0);
        instr_ready = 1'b1;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            chk("t2_drain_valid", 32'(instr_valid), 1);
            chk("t2_drain_pc",    32'(instr_pc), 32'(i));
        end

        // Redirect to 0x20 with 3 buffered + 1 inflight
        reset = 1'b1; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_pre_en",    32'(enable_to_rom), 0);
        chk("t3_pre_valid", 32'(instr_valid), 1);
        redirect = 1'b1; redirect_addr = 6'h20;
        @(negedge clk);
        redirect = 1'b0; #1;
        chk("t3_valid_a", 32'(instr_valid), 0);
        chk("t3_en",      32'(enable_to_rom), 1);
        chk("t3_addr",    32'(address_to_rom), 32'h20);
        chk_perf("t3_perf", 8'd4);
        @(negedge clk);
        chk("t3_valid_b", 32'(instr_valid), 0);
        @(negedge clk);
        chk("t3_valid_c", 32'(instr_valid), 1);
        chk("t3_pc",      32'(instr_pc), 32'h20);
        chk("t3_out",     32'(instr_out), 32'h20);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("t3_pc_next", 32'(instr_pc), 32'h21);

        // Wrap from 0x3E
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; redirect = 1'b1; redirect_addr = 6'h3E; #1;
        chk("t4_en_redir", 32'(enable_to_rom), 0);
        @(negedge clk);
        redirect = 1'b0; #1;
        chk("t4_en",    32'(enable_to_rom), 1);
        chk("t4_addr0", 32'(address_to_rom), 32'h3E);
        @(negedge clk);
        chk("t4_addr1",  32'(address_to_rom), 32'h3F);
        chk("t4_valid0", 32'(instr_valid), 0);
        @(negedge clk);
        chk("t4_addr2", 32'(address_to_rom), 32'h00);
        chk("t4_pc0",   32'(instr_pc), 32'h3E);
        @(negedge clk);
        chk("t4_pc1", 32'(instr_pc), 32'h3F);
        @(negedge clk);
        chk("t4_pc2", 32'(instr_pc), 32'h00);
        @(negedge clk);
        chk("t4_pc3",    32'(instr_pc), 32'h01);
        chk("t4_out3",   32'(instr_out), 32'h01);
        chk("t4_valid3", 32'(instr_valid), 1);
        chk_perf("t4_perf", 8'd0);

        // Redirect on a popping cycle, then a second redirect to 0x10
        redirect = 1'b1; redirect_addr = 6'h08;
        @(negedge clk);
        chk("t5_valid_a", 32'(instr_valid), 0);
        redirect_addr = 6'h10; #1;
        chk("t5_en_redir", 32'(enable_to_rom), 0);
        @(negedge clk);
        redirect = 1'b0; #1;
        chk("t5_valid_b", 32'(instr_valid), 0);
        chk("t5_addr",    32'(address_to_rom), 32'h10);
        @(negedge clk);
        chk("t5_valid_c", 32'(instr_valid), 0);
        @(negedge clk);
        chk("t5_valid_d", 32'(instr_valid), 1);
        chk("t5_pc0",     32'(instr_pc), 32'h10);
        @(negedge clk);
        chk("t5_pc1", 32'(instr_pc), 32'h11);
        chk_perf("t5_perf", 8'd2);

        // Fill, then a 1-cycle reset mid-stream
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_full_en",    32'(enable_to_rom), 0);
        chk("t6_full_valid", 32'(instr_valid), 1);
        chk("t6_full_pc",    32'(instr_pc), 32'h11);
        reset = 1'b1; #1;
        chk("t6_rst_en", 32'(enable_to_rom), 0);
        @(negedge clk);
        reset = 1'b0; #1;
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_en",    32'(enable_to_rom), 1);
        chk("t6_addr",  32'(address_to_rom), 0);
        chk_perf("t6_perf", 8'd0);
        repeat (2) @(negedge clk);
        chk("t6_valid2", 32'(instr_valid), 1);
        chk("t6_pc",     32'(instr_pc), 0);
        chk("t6_out",    32'(instr_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
